// File: rtl/dynode_energy_integ.sv
// Baseline-subtracted dynode energy integrator: sums (16*adc - bl12) over a window per event
// and presents the result through a valid/ack handshake. Optional macro: DYN_PUREJECT_EN.
module dynode_energy_integ #(
  parameter int ACCW  = 20,
  parameter int DROPW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dyn_event,
  input  logic             dyn_pileup,
  input  logic [7:0]       dyn_adcdly,
  input  logic [15:0]      dyn_curval,
  input  logic [5:0]       intlen,
  input  logic [3:0]       holdoff,
  input  logic             dyn_ene_ack,
  output logic [15:0]      dyn_energy,
  output logic             dyn_ene_pu,
  output logic             dyn_ene_valid,
  output logic             dyn_busy,
  output logic [DROPW-1:0] dyn_drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INTEG = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_event_d;
  logic                    r_pileup_d;
  logic                    r_armed;
  logic [11:0]             r_bl12;
  logic signed [ACCW-1:0]  r_acc;
  logic [6:0]              r_cnt;
  logic [6:0]              r_len;
  logic [3:0]              r_hcnt;
  logic                    r_pu_flag;
  logic [15:0]             r_energy;
  logic                    r_ene_pu;
  logic                    r_ene_valid;
  logic [DROPW-1:0]        r_drop_cnt;

  logic                    w_start;
  logic                    w_pu_rise;
  logic [11:0]             w_bl_use;
  logic signed [ACCW-1:0]  w_corr;
  logic signed [ACCW-1:0]  w_sum;
  logic [6:0]              w_len_now;
  logic [6:0]              w_cnt_next;
  logic                    w_pu_next;
  logic                    w_last;
  logic                    w_publish;
  logic                    w_reject;
  logic                    w_drop_inc;

  function automatic logic [6:0] len_decode(input logic [5:0] l);
    return (l == 6'd0) ? 7'd64 : {1'b0, l};
  endfunction

  function automatic logic signed [ACCW-1:0] corr_sample(input logic [7:0] adc,
                                                         input logic [11:0] bl);
    logic signed [12:0] c;
    c = $signed({1'b0, adc, 4'b0000}) - $signed({1'b0, bl});
    return {{(ACCW-13){c[12]}}, c};
  endfunction

  // Negative sums clamp to 0, oversize sums to full scale; result is in ADC LSB units.
  function automatic logic [15:0] clamp_energy(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] sh;
    sh = a >>> 4;
    if (a[ACCW-1])
      return 16'h0000;
    else if (sh > $signed({{(ACCW-16){1'b0}}, 16'hFFFF}))
      return 16'hFFFF;
    else
      return sh[15:0];
  endfunction

  function automatic logic [DROPW-1:0] sat_inc(input logic [DROPW-1:0] v);
    return (&v) ? v : v + {{(DROPW-1){1'b0}}, 1'b1};
  endfunction

  assign w_start   = dyn_event & ~r_event_d & r_armed;
  assign w_pu_rise = dyn_pileup & ~r_pileup_d;

  // In the start cycle the baseline and length come straight from the inputs.
  always_comb begin
    w_bl_use   = r_bl12;
    w_len_now  = r_len;
    w_sum      = r_acc + w_corr;
    w_cnt_next = r_cnt + 7'd1;
    w_pu_next  = r_pu_flag | w_pu_rise | dyn_pileup;
    w_last     = 1'b0;
    if (r_state == ST_IDLE) begin
      w_bl_use   = dyn_curval[15:4];
      w_len_now  = len_decode(intlen);
      w_sum      = w_corr;
      w_cnt_next = 7'd1;
      w_pu_next  = dyn_pileup;
      w_last     = w_start && (w_len_now == 7'd1);
    end else if (r_state == ST_INTEG) begin
      w_last     = (w_cnt_next == r_len);
    end
  end

  assign w_corr = corr_sample(dyn_adcdly, w_bl_use);

`ifdef DYN_PUREJECT_EN
  assign w_publish = w_last & ~w_pu_next;
  assign w_reject  = w_last &  w_pu_next;
`else
  assign w_publish = w_last;
  assign w_reject  = 1'b0;
`endif

  assign w_drop_inc = w_reject | (w_publish & r_ene_valid & ~dyn_ene_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_event_d  <= 1'b0;
      r_pileup_d <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_event_d  <= dyn_event;
      r_pileup_d <= dyn_pileup;
      r_armed    <= r_armed | ~dyn_event;
    end
  end

  // Window sequencer: IDLE -> INTEG -> HOLD -> IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bl12    <= 12'd0;
      r_acc     <= '0;
      r_cnt     <= 7'd0;
      r_len     <= 7'd0;
      r_hcnt    <= 4'd0;
      r_pu_flag <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_bl12    <= dyn_curval[15:4];
            r_len     <= w_len_now;
            r_acc     <= w_sum;
            r_cnt     <= w_cnt_next;
            r_pu_flag <= w_pu_next;
            if (w_last) begin
              r_state <= ST_HOLD;
              r_hcnt  <= holdoff;
            end else begin
              r_state <= ST_INTEG;
            end
          end
        end
        ST_INTEG: begin
          r_acc     <= w_sum;
          r_cnt     <= w_cnt_next;
          r_pu_flag <= w_pu_next;
          if (w_last) begin
            r_state <= ST_HOLD;
            r_hcnt  <= holdoff;
          end
        end
        ST_HOLD: begin
          if (r_hcnt == 4'd0)
            r_state <= ST_IDLE;
          else
            r_hcnt <= r_hcnt - 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output word: a publish while an unacked word is pending is dropped and counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_energy    <= 16'd0;
      r_ene_pu    <= 1'b0;
      r_ene_valid <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (r_ene_valid && dyn_ene_ack)
        r_ene_valid <= 1'b0;
      if (w_publish && (!r_ene_valid || dyn_ene_ack)) begin
        r_energy    <= clamp_energy(w_sum);
`ifdef DYN_PUREJECT_EN
        r_ene_pu    <= 1'b0;
`else
        r_ene_pu    <= w_pu_next;
`endif
        r_ene_valid <= 1'b1;
      end
      if (w_drop_inc)
        r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign dyn_energy    = r_energy;
  assign dyn_ene_pu    = r_ene_pu;
  assign dyn_ene_valid = r_ene_valid;
  assign dyn_busy      = (r_state != ST_IDLE);
  assign dyn_drop_cnt  = r_drop_cnt;

endmodule
